// File: rtl/mc_ctrl_fsm.sv
// Multicycle control sequencer for the OTTER MCU.
// It fetches an instruction over a req/ack handshake and latches it into IR.
// It decodes the opcode into an immediate-format select, then sequences
// execute, data-memory access, writeback and trap entry.
// The memory request lines are registered from the next state. They are 0 while
// reset is asserted and drop in the same cycle that reset asserts.
// Because of this, the first FETCH cycle after reset has no request.
module mc_ctrl_fsm #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [2:0]  imm_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        pc_we,
  output logic        rf_we,
  input  logic        intr,
  input  logic        int_en,
  output logic        trap_taken,
  output logic [1:0]  trap_cause,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam logic [1:0] CAUSE_INT = 2'd0;
  localparam logic [1:0] CAUSE_ILL = 2'd1;
  localparam logic [1:0] CAUSE_BUS = 2'd2;

  // Last count value before the limit: a request that is still unacked when
  // the counter holds this value has waited TIMEOUT_CYCLES cycles.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  to_cnt;
  logic [1:0]  cause_nxt;
  logic [2:0]  dec_imm;
  logic        dec_legal;
  logic [6:0]  opc;
  logic        is_load, is_store, is_mem, no_rf;
  logic        irq_take;

  assign opc      = ir[6:0];
  assign is_load  = (opc == OP_LOAD);
  assign is_store = (opc == OP_STORE);
  assign is_mem   = is_load | is_store;
  assign no_rf    = (opc == OP_BRANCH) | (opc == OP_SYSTEM);
  assign irq_take = intr & int_en;

  // Opcode to immediate format. Anything not listed, including IR[1:0] != 2'b11, is illegal.
  always_comb begin
    dec_imm   = IMM_NONE;
    dec_legal = 1'b1;
    case (opc)
      OP_LUI, OP_AUIPC:                       dec_imm = IMM_U;
      OP_JAL:                                 dec_imm = IMM_J;
      OP_JALR, OP_LOAD, OP_OPIMM, OP_SYSTEM:  dec_imm = IMM_I;
      OP_STORE:                               dec_imm = IMM_S;
      OP_BRANCH:                              dec_imm = IMM_B;
      OP_OP:                                  dec_imm = IMM_NONE;
      default: begin
        dec_imm   = IMM_NONE;
        dec_legal = 1'b0;
      end
    endcase
  end

  // Next-state logic and the cause to record on entry to TRAP.
  always_comb begin
    state_nxt = state;
    cause_nxt = trap_cause;
    case (state)
      S_FETCH: begin
        if (imem_req) begin
          if (imem_ack) begin
            state_nxt = S_DECODE;
          end else if (to_cnt == TO_LAST) begin
            state_nxt = S_TRAP;
            cause_nxt = CAUSE_BUS;
          end
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_nxt = S_EXEC;
        end else begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_ILL;
        end
      end
      S_EXEC: begin
        if (is_mem) begin
          state_nxt = S_MEM;
        end else if (irq_take) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_INT;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        if (dmem_req) begin
          if (dmem_ack) begin
            state_nxt = S_WB;
          end else if (to_cnt == TO_LAST) begin
            state_nxt = S_TRAP;
            cause_nxt = CAUSE_BUS;
          end
        end
      end
      S_WB: begin
        if (irq_take) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_INT;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_TRAP:  state_nxt = S_FETCH;
      default: state_nxt = S_FETCH;
    endcase
  end

  // State register, timeout counter and registered request lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      to_cnt   <= 8'd0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
    end else begin
      state    <= state_nxt;
      imem_req <= (state_nxt == S_FETCH);
      dmem_req <= (state_nxt == S_MEM);
      dmem_we  <= (state_nxt == S_MEM) & is_store;
      if (state_nxt != state)
        to_cnt <= 8'd0;
      else if ((state == S_FETCH && imem_req && !imem_ack) ||
               (state == S_MEM && dmem_req && !dmem_ack))
        to_cnt <= to_cnt + 8'd1;
    end
  end

  // IR, immediate select and trap cause: each is loaded only at its own event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir         <= 32'd0;
      imm_sel    <= IMM_NONE;
      trap_cause <= CAUSE_INT;
    end else begin
      if (state == S_FETCH && imem_req && imem_ack)
        ir <= imem_rdata;
      if (state == S_DECODE)
        imm_sel <= dec_imm;
      if (state_nxt == S_TRAP && state != S_TRAP)
        trap_cause <= cause_nxt;
    end
  end

  // Strobes decoded from the state register and IR only.
  always_comb begin
    pc_we      = ((state == S_EXEC) & ~is_mem) | (state == S_WB);
    rf_we      = ((state == S_EXEC) & ~is_mem & ~no_rf) | ((state == S_WB) & is_load);
    trap_taken = (state == S_TRAP);
    busy       = (state != S_FETCH);
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm (TIMEOUT_CYCLES=4).
// A transaction-level model turns each instruction and its handshake timing
// into the output vector expected on every cycle. Literal checks pin the model.
module tb_mc_ctrl_fsm;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, intr = 1'b0, int_en = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req, dmem_req, dmem_we, pc_we, rf_we, trap_taken, busy;
  logic [31:0] ir;
  logic [2:0]  imm_sel;
  logic [1:0]  trap_cause;

  mc_ctrl_fsm #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .imm_sel(imm_sel), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ack(dmem_ack), .pc_we(pc_we), .rf_we(rf_we),
    .intr(intr), .int_en(int_en), .trap_taken(trap_taken),
    .trap_cause(trap_cause), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        imem_req, dmem_req, dmem_we, pc_we, rf_we, trap_taken, busy;
    logic [2:0]  imm_sel;
    logic [1:0]  trap_cause;
    logic [31:0] ir;
  } vec_t;

  int errors = 0, checks = 0, cyc = 0;
  int n_ireq, n_dreq, n_dwe, n_pc, n_rf, n_trap;
  logic [2:0]  m_imm = 3'd7;
  logic [1:0]  m_cause = 2'd0;
  logic [31:0] m_ir = 32'd0;

  function automatic logic [2:0] imm_of(input logic [6:0] op, output bit legal);
    legal = 1'b1;
    case (op)
      7'b0110111, 7'b0010111: return 3'd3;
      7'b1101111: return 3'd4;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: return 3'd0;
      7'b0100011: return 3'd1;
      7'b1100011: return 3'd2;
      7'b0110011: return 3'd7;
      default: begin legal = 1'b0; return 3'd7; end
    endcase
  endfunction

  function automatic vec_t base();
    vec_t v = '0;
    v.imm_sel = m_imm; v.trap_cause = m_cause; v.ir = m_ir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One cycle: compare every output against the model mid-cycle, tally pulses.
  task automatic step(input vec_t e);
    vec_t g;
    @(negedge clk);
    g = '{imem_req, dmem_req, dmem_we, pc_we, rf_we, trap_taken, busy,
          imm_sel, trap_cause, ir};
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL cycle %0d: got %h expected %h", cyc, g, e);
    end
    n_ireq += int'(imem_req); n_dreq += int'(dmem_req); n_dwe += int'(dmem_we);
    n_pc += int'(pc_we); n_rf += int'(rf_we); n_trap += int'(trap_taken);
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic trap_step();
    vec_t e = base();
    e.trap_taken = 1'b1; e.busy = 1'b1;
    step(e);
  endtask

  task automatic idle_after_reset();
    m_imm = 3'd7; m_cause = 2'd0; m_ir = 32'd0;
    step(base());
  endtask

  // iack/dack: cycle of the request phase on which ACK arrives (0 = never).
  // rst_at: assert reset in that MEM cycle (0 = no reset).
  task automatic run_instr(input logic [31:0] ins, input int iack, input int dack,
                           input bit irq, input bit en, input int rst_at);
    vec_t e; bit legal; logic [2:0] imm; logic [6:0] op;
    int n;
    op = ins[6:0];
    n_ireq = 0; n_dreq = 0; n_dwe = 0; n_pc = 0; n_rf = 0; n_trap = 0;
    n = (iack == 0) ? T : iack;
    for (int k = 1; k <= n; k++) begin
      imem_ack = (k == iack);
      imem_rdata = (k == iack) ? ins : 32'hDEADBEEF;
      e = base(); e.imem_req = 1'b1;
      step(e);
    end
    imem_ack = 1'b0;
    if (iack == 0) begin m_cause = 2'd2; trap_step(); return; end
    m_ir = ins;
    intr = irq; int_en = en;
    e = base(); e.busy = 1'b1;
    step(e);
    imm = imm_of(op, legal);
    m_imm = imm;
    if (!legal) begin
      intr = 1'b0; int_en = 1'b0;
      m_cause = 2'd1; trap_step(); return;
    end
    e = base(); e.busy = 1'b1;
    if (op == 7'b0000011 || op == 7'b0100011) begin
      step(e);
      n = (dack == 0) ? T : dack;
      for (int k = 1; k <= n; k++) begin
        if (k == rst_at) begin
          #2 rst_n = 1'b0;
          #1;
          chk("rst_dmem_req", 32'(dmem_req), 32'd0);
          chk("rst_imm_sel", 32'(imm_sel), 32'd7);
          chk("rst_busy", 32'(busy), 32'd0);
          chk("rst_ir", ir, 32'd0);
          intr = 1'b0; int_en = 1'b0;
          @(posedge clk); #1;
          rst_n = 1'b1;
          idle_after_reset();
          return;
        end
        dmem_ack = (k == dack);
        e = base(); e.busy = 1'b1; e.dmem_req = 1'b1; e.dmem_we = (op == 7'b0100011);
        step(e);
      end
      dmem_ack = 1'b0;
      if (dack == 0) begin
        intr = 1'b0; int_en = 1'b0;
        m_cause = 2'd2; trap_step(); return;
      end
      e = base(); e.busy = 1'b1; e.pc_we = 1'b1; e.rf_we = (op == 7'b0000011);
      step(e);
    end else begin
      e.pc_we = 1'b1;
      e.rf_we = !(op == 7'b1100011 || op == 7'b1110011);
      step(e);
    end
    intr = 1'b0; int_en = 1'b0;
    if (irq && en) begin m_cause = 2'd0; trap_step(); end
  endtask

  logic [31:0] sweep_ins [7] = '{32'h12345037, 32'h00000017, 32'h0000006F,
                                 32'h00008067, 32'h00208463, 32'h0020A023, 32'h002081B3};
  logic [2:0]  sweep_imm [7] = '{3'd3, 3'd3, 3'd4, 3'd0, 3'd2, 3'd1, 3'd7};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_imem_req", 32'(imem_req), 32'd0);
    chk("reset_imm_sel", 32'(imm_sel), 32'd7);
    chk("reset_ir", ir, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle_after_reset();

    // ADDI, ACK on first request cycle
    run_instr(32'h00500093, 1, 0, 1'b0, 1'b0, 0);
    chk("addi_ir", ir, 32'h00500093);
    chk("addi_imm", 32'(imm_sel), 32'd0);
    chk("addi_pc_rf", {n_pc, n_rf}, {32'd1, 32'd1});

    // LW, DMEM_ACK after 3 wait cycles
    run_instr(32'h0000A103, 2, 4, 1'b0, 1'b0, 0);
    chk("lw_dreq_cycles", n_dreq, 4);
    chk("lw_dwe", n_dwe, 0);
    chk("lw_rf", n_rf, 1);

    // SW
    run_instr(32'h0020A023, 1, 1, 1'b0, 1'b0, 0);
    chk("sw_dwe", n_dwe, 1);
    chk("sw_imm", 32'(imm_sel), 32'd1);
    chk("sw_rf", n_rf, 0);

    // opcode sweep
    for (int i = 0; i < 7; i++) begin
      run_instr(sweep_ins[i], 1, 0, 1'b0, 1'b0, 0);
      chk("sweep_imm", 32'(imm_sel), 32'(sweep_imm[i]));
    end

    // illegal opcodes
    run_instr(32'hFFFFFFFF, 1, 0, 1'b0, 1'b0, 0);
    chk("ill_trap", n_trap, 1);
    chk("ill_cause", 32'(trap_cause), 32'd1);
    chk("ill_pc_rf", {n_pc, n_rf}, {32'd0, 32'd0});
    run_instr(32'h00000031, 1, 0, 1'b0, 1'b0, 0);
    chk("ill_low_bits", n_trap, 1);

    // fetch timeout, then ACK exactly on the limit cycle
    run_instr(32'h00500093, 0, 0, 1'b0, 1'b0, 0);
    chk("to_req_cycles", n_ireq, 4);
    chk("to_cause", 32'(trap_cause), 32'd2);
    run_instr(32'h00500093, 4, 0, 1'b0, 1'b0, 0);
    chk("ack_at_limit", n_trap, 0);

    // data timeout
    run_instr(32'h0000A103, 1, 0, 1'b0, 1'b0, 0);
    chk("dto_dreq", n_dreq, 4);
    chk("dto_trap", n_trap, 1);

    // interrupt disabled, then enabled, at the ADD boundary
    run_instr(32'h002081B3, 1, 0, 1'b1, 1'b0, 0);
    chk("irq_masked", n_trap, 0);
    run_instr(32'h002081B3, 1, 0, 1'b1, 1'b1, 0);
    chk("irq_pc", n_pc, 1);
    chk("irq_trap", n_trap, 1);
    chk("irq_cause", 32'(trap_cause), 32'd0);

    // interrupt at the WB boundary of a load
    run_instr(32'h0000A103, 1, 2, 1'b1, 1'b1, 0);
    chk("wb_irq_trap", n_trap, 1);

    // SYSTEM: commits PC without a register write
    run_instr(32'h00000073, 1, 0, 1'b0, 1'b0, 0);
    chk("sys_pc_rf", {n_pc, n_rf}, {32'd1, 32'd0});

    // reset mid-MEM with DMEM_REQ high
    run_instr(32'h0000A103, 1, 0, 1'b0, 1'b0, 3);
    run_instr(32'h00500093, 1, 0, 1'b0, 1'b0, 0);
    chk("post_reset_ir", ir, 32'h00500093);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
